// File: rtl/mips_tb_pkg.sv
// Shared types and defaults for the MIPS result monitor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_tb_pkg;

  // Default parameter values for the monitor.
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_NUM_CHECKS = 4;
  localparam int DEF_TMO_W      = 16;

  // Status field widths: up to 16 slots, so a 4-bit index and a 5-bit count.
  localparam int IDX_W = 4;
  localparam int ERR_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_CHECK = 3'd2,
    ST_DONE  = 3'd3,
    ST_TMO   = 3'd4
  } state_t;

endpackage

// File: rtl/mips_result_slot.sv
// One result slot: snoops data-memory writes to its address, keeps a shadow copy.
// Latency: shadow/valid update on the edge that samples the write; mismatch is combinational.
// Backpressure: none; every enabled write is absorbed.
//
// Ports:
//   i_clk, i_rst_n     clock, async active-low reset
//   i_clr              synchronous clear of shadow and valid (run launch)
//   i_wr_en            snooped write enable, already qualified by the RUN state
//   i_slot_addr        word address this slot watches
//   i_wr_addr/i_wr_data snooped write address and data
//   i_exp_data         expected value for this slot
//   o_mismatch         slot never written, or shadow differs from expected
module mips_result_slot
  import mips_tb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_slot_addr,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [DATA_W-1:0] i_exp_data,
  output logic              o_mismatch
);

  logic [DATA_W-1:0] shadow;
  logic              valid;
  logic              hit;

  assign hit = i_wr_en && (i_wr_addr == i_slot_addr);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shadow <= '0;
      valid  <= 1'b0;
    end else if (i_clr) begin
      shadow <= '0;
      valid  <= 1'b0;
    end else if (hit) begin
      shadow <= i_wr_data;
      valid  <= 1'b1;
    end
  end

  // An unwritten slot counts as a failure even if its expected value is 0.
  assign o_mismatch = !valid || (shadow != i_exp_data);

endmodule

// File: rtl/mips_result_monitor.sv
// Holds a MIPS core in reset, runs it, snoops its result writes and grades them per slot.
// Latency: pass/fail valid NUM_CHECKS+1 cycles after the completion write; timeout after i_timeout RUN cycles.
// Backpressure: none; snooped writes are observed, never stalled.
//
// Ports:
//   i_clk, i_rst_n            clock, async active-low reset
//   i_start                   launch pulse (honoured in IDLE, DONE, TMO)
//   i_done_addr               address of the completion flag word (value 1 completes)
//   i_chk_addr / i_chk_exp    packed per-slot address / expected value
//   i_timeout                 RUN cycle limit, 0 disables
//   i_mem_we/addr/wdata       snooped data-memory write port
//   o_core_rst_n              core reset, released only in RUN
//   o_busy/o_done/o_pass/o_timeout  run status
//   o_err_cnt/o_first_fail    mismatch count and lowest failing slot
module mips_result_monitor
  import mips_tb_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int NUM_CHECKS = DEF_NUM_CHECKS,
  parameter int TMO_W      = DEF_TMO_W
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_start,
  input  logic [ADDR_W-1:0]            i_done_addr,
  input  logic [NUM_CHECKS*ADDR_W-1:0] i_chk_addr,
  input  logic [NUM_CHECKS*DATA_W-1:0] i_chk_exp,
  input  logic [TMO_W-1:0]             i_timeout,
  input  logic                         i_mem_we,
  input  logic [ADDR_W-1:0]            i_mem_addr,
  input  logic [DATA_W-1:0]            i_mem_wdata,
  output logic                         o_core_rst_n,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_pass,
  output logic                         o_timeout,
  output logic [ERR_W-1:0]             o_err_cnt,
  output logic [IDX_W-1:0]             o_first_fail
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHECKS - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [TMO_W-1:0]        cyc_cnt;
  logic [TMO_W-1:0]        cyc_inc;
  logic [IDX_W-1:0]        chk_idx;
  logic [ERR_W-1:0]        err_cnt;
  logic [IDX_W-1:0]        first_fail;
  logic [NUM_CHECKS-1:0]   mismatch_vec;
  logic [15:0]             mismatch_pad;

  logic in_run;
  logic in_check;
  logic run_we;
  logic start_go;
  logic completion;
  logic tmo_hit;
  logic chk_last;
  logic cur_mismatch;

  assign in_run   = (state == ST_RUN);
  assign in_check = (state == ST_CHECK);
  assign run_we   = in_run && i_mem_we;

  // i_start is only honoured when no run is in flight.
  assign start_go = i_start &&
                    ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_TMO));

  assign completion = run_we && (i_mem_addr == i_done_addr) &&
                      (i_mem_wdata == DATA_W'(1));

  // cyc_inc is the number of RUN cycles including the current one.
  assign cyc_inc  = cyc_cnt + TMO_W'(1);
  assign tmo_hit  = (i_timeout != '0) && (cyc_inc == i_timeout);
  assign chk_last = (chk_idx == LAST_IDX);

  // Slots: capture happens on the same edge as a completion write, so the
  // first CHECK cycle already sees a write that also hit the done address.
  for (genvar k = 0; k < NUM_CHECKS; k++) begin : g_slot
    mips_result_slot #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_slot (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_clr       (start_go),
      .i_wr_en     (run_we),
      .i_slot_addr (i_chk_addr[k*ADDR_W +: ADDR_W]),
      .i_wr_addr   (i_mem_addr),
      .i_wr_data   (i_mem_wdata),
      .i_exp_data  (i_chk_exp[k*DATA_W +: DATA_W]),
      .o_mismatch  (mismatch_vec[k])
    );
  end

  // Pad to the full 16-slot index space so chk_idx can select directly.
  always_comb begin
    mismatch_pad = '0;
    mismatch_pad[NUM_CHECKS-1:0] = mismatch_vec;
  end

  assign cur_mismatch = mismatch_pad[chk_idx];

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; completion wins over a coincident timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_go) state_nxt = ST_RUN;
      ST_RUN: begin
        if (completion)   state_nxt = ST_CHECK;
        else if (tmo_hit) state_nxt = ST_TMO;
      end
      ST_CHECK: if (chk_last) state_nxt = ST_DONE;
      ST_DONE:  if (start_go) state_nxt = ST_RUN;
      ST_TMO:   if (start_go) state_nxt = ST_RUN;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Run counter, check index and grading results
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cyc_cnt    <= '0;
      chk_idx    <= '0;
      err_cnt    <= '0;
      first_fail <= '0;
    end else if (start_go) begin
      cyc_cnt    <= '0;
      chk_idx    <= '0;
      err_cnt    <= '0;
      first_fail <= '0;
    end else begin
      if (in_run) begin
        cyc_cnt <= cyc_inc;
      end
      if (in_check) begin
        chk_idx <= chk_last ? '0 : chk_idx + IDX_W'(1);
        if (cur_mismatch) begin
          err_cnt <= err_cnt + ERR_W'(1);
          // Slots are graded in ascending order, so the first hit is the lowest.
          if (err_cnt == '0) begin
            first_fail <= chk_idx;
          end
        end
      end
    end
  end

  assign o_core_rst_n = in_run;
  assign o_busy       = in_run || in_check;
  assign o_done       = (state == ST_DONE) || (state == ST_TMO);
  assign o_pass       = (state == ST_DONE) && (err_cnt == '0);
  assign o_timeout    = (state == ST_TMO);
  assign o_err_cnt    = err_cnt;
  assign o_first_fail = first_fail;

endmodule

// File: tb/tb_mips_result_monitor.sv
// Bench for mips_result_monitor: directed runs against a memory-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mips_result_monitor;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int N  = 4;
  localparam int TW = 16;

  localparam int P_IDLE  = 0;
  localparam int P_RUN   = 1;
  localparam int P_CHECK = 2;
  localparam int P_DONE  = 3;
  localparam int P_TMO   = 4;

  logic              i_clk;
  logic              i_rst_n;
  logic              i_start;
  logic [AW-1:0]     i_done_addr;
  logic [N*AW-1:0]   i_chk_addr;
  logic [N*DW-1:0]   i_chk_exp;
  logic [TW-1:0]     i_timeout;
  logic              i_mem_we;
  logic [AW-1:0]     i_mem_addr;
  logic [DW-1:0]     i_mem_wdata;
  logic              o_core_rst_n;
  logic              o_busy;
  logic              o_done;
  logic              o_pass;
  logic              o_timeout;
  logic [4:0]        o_err_cnt;
  logic [3:0]        o_first_fail;

  mips_result_monitor #(
    .DATA_W     (DW),
    .ADDR_W     (AW),
    .NUM_CHECKS (N),
    .TMO_W      (TW)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_done_addr  (i_done_addr),
    .i_chk_addr   (i_chk_addr),
    .i_chk_exp    (i_chk_exp),
    .i_timeout    (i_timeout),
    .i_mem_we     (i_mem_we),
    .i_mem_addr   (i_mem_addr),
    .i_mem_wdata  (i_mem_wdata),
    .o_core_rst_n (o_core_rst_n),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_pass       (o_pass),
    .o_timeout    (o_timeout),
    .o_err_cnt    (o_err_cnt),
    .o_first_fail (o_first_fail)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  bit compare_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference model: a plain memory image of what the core wrote during the
  // run; grading is done all at once when the completion word lands.
  int          m_phase   = P_IDLE;
  int          m_run_cyc = 0;
  int          m_chk_left = 0;
  int          m_err     = 0;
  int          m_ff      = 0;
  logic [DW-1:0] mem_val [256];
  bit            mem_wr  [256];

  task automatic model_clear();
    for (int a = 0; a < 256; a++) mem_wr[a] = 1'b0;
    m_run_cyc = 0;
    m_err     = 0;
    m_ff      = 0;
  endtask

  task automatic model_grade();
    for (int k = 0; k < N; k++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] e;
      a = i_chk_addr[k*AW +: AW];
      e = i_chk_exp[k*DW +: DW];
      if (!mem_wr[a] || (mem_val[a] !== e)) begin
        if (m_err == 0) m_ff = k;
        m_err++;
      end
    end
  endtask

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_phase = P_IDLE;
      model_clear();
    end else begin
      case (m_phase)
        P_RUN: begin
          m_run_cyc++;
          if (i_mem_we) begin
            mem_val[i_mem_addr] = i_mem_wdata;
            mem_wr[i_mem_addr]  = 1'b1;
          end
          if (i_mem_we && i_mem_addr == i_done_addr && i_mem_wdata == 1) begin
            model_grade();
            m_chk_left = N;
            m_phase = P_CHECK;
          end else if (i_timeout != 0 && m_run_cyc == int'(i_timeout)) begin
            m_phase = P_TMO;
          end
        end
        P_CHECK: begin
          m_chk_left--;
          if (m_chk_left == 0) m_phase = P_DONE;
        end
        default: begin
          if (i_start) begin
            model_clear();
            m_phase = P_RUN;
          end
        end
      endcase
    end
  end

  // Per-cycle comparison against the model
  always @(negedge i_clk) begin
    if (compare_en) begin
      chk("core_rst_n", int'(o_core_rst_n), int'(m_phase == P_RUN));
      chk("busy", int'(o_busy), int'(m_phase == P_RUN || m_phase == P_CHECK));
      chk("done", int'(o_done), int'(m_phase == P_DONE || m_phase == P_TMO));
      chk("timeout", int'(o_timeout), int'(m_phase == P_TMO));
      chk("pass", int'(o_pass), int'(m_phase == P_DONE && m_err == 0));
      if (m_phase != P_CHECK) begin
        chk("err_cnt", int'(o_err_cnt), m_err);
        chk("first_fail", int'(o_first_fail), m_ff);
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    i_mem_we    = 1'b1;
    i_mem_addr  = AW'(a);
    i_mem_wdata = d;
    tick();
    i_mem_we    = 1'b0;
  endtask

  task automatic start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic set_slot(input int k, input int a, input logic [DW-1:0] e);
    i_chk_addr[k*AW +: AW] = AW'(a);
    i_chk_exp[k*DW +: DW]  = e;
  endtask

  // Counts edges since the completion write until o_done; 'lat_in' is the
  // number of edges already consumed (the completion edge counts as 1).
  task automatic wait_done(input int lat_in, output int lat);
    lat = lat_in;
    while (!o_done && lat < 40) begin
      tick();
      lat++;
    end
    chk("done_seen", int'(o_done), 1);
  endtask

  task automatic chk_all_reset(input string tag);
    chk({tag, "_core_rst_n"}, int'(o_core_rst_n), 0);
    chk({tag, "_busy"}, int'(o_busy), 0);
    chk({tag, "_done"}, int'(o_done), 0);
    chk({tag, "_pass"}, int'(o_pass), 0);
    chk({tag, "_timeout"}, int'(o_timeout), 0);
    chk({tag, "_err_cnt"}, int'(o_err_cnt), 0);
    chk({tag, "_first_fail"}, int'(o_first_fail), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int k;
    i_rst_n     = 1'b0;
    i_start     = 1'b0;
    i_done_addr = '0;
    i_chk_addr  = '0;
    i_chk_exp   = '0;
    i_timeout   = '0;
    i_mem_we    = 1'b0;
    i_mem_addr  = '0;
    i_mem_wdata = '0;
    repeat (3) tick();
    chk_all_reset("por");
    i_rst_n = 1'b1;
    tick();
    compare_en = 1'b1;
    tick();

    // Basic pass: all slots watch mem[5]=3500, done at 0
    for (int s = 0; s < N; s++) set_slot(s, 5, 32'd3500);
    i_done_addr = 8'd0;
    start();
    wr(5, 32'd3500);
    wr(0, 32'd1);
    wait_done(1, lat);
    chk("t1_latency", lat, N + 1);
    chk("t1_pass", int'(o_pass), 1);
    chk("t1_err", int'(o_err_cnt), 0);

    // One wrong value in slot 3, boundary-valued expectations elsewhere
    set_slot(0, 15, 32'd100);
    set_slot(1, 16, 32'h8000_0000);
    set_slot(2, 17, 32'd200);
    set_slot(3, 18, 32'h7FFF_FFFF);
    start();
    wr(15, 32'd100);
    wr(16, 32'h8000_0000);
    wr(17, 32'd200);
    wr(18, 32'h7FFF_FFFE);
    wr(0, 32'd1);
    wait_done(1, lat);
    chk("t2_latency", lat, N + 1);
    chk("t2_pass", int'(o_pass), 0);
    chk("t2_err", int'(o_err_cnt), 1);
    chk("t2_first_fail", int'(o_first_fail), 3);

    // Slot 1 at addr 12 never written, done at 11
    set_slot(0, 20, 32'd1);
    set_slot(1, 12, 32'd2);
    set_slot(2, 22, 32'd3);
    set_slot(3, 23, 32'd4);
    i_done_addr = 8'd11;
    start();
    wr(20, 32'd1);
    wr(22, 32'd3);
    wr(23, 32'd4);
    wr(11, 32'd1);
    wait_done(1, lat);
    chk("t3_err", int'(o_err_cnt), 1);
    chk("t3_first_fail", int'(o_first_fail), 1);

    // Done word written with 2 must not complete; the later 1 does
    set_slot(0, 5, 32'd11);
    set_slot(1, 6, 32'd22);
    set_slot(2, 7, 32'd33);
    set_slot(3, 8, 32'd44);
    i_done_addr = 8'd0;
    start();
    wr(5, 32'd11);
    wr(6, 32'd22);
    wr(7, 32'd33);
    wr(8, 32'd44);
    wr(0, 32'd2);
    repeat (3) tick();
    chk("t4_still_busy", int'(o_busy), 1);
    wr(0, 32'd1);
    wait_done(1, lat);
    chk("t4_pass", int'(o_pass), 1);

    // Same write hits slot 0 and the done word; write during CHECK ignored
    set_slot(0, 5, 32'd1);
    i_done_addr = 8'd5;
    start();
    wr(6, 32'd22);
    wr(7, 32'd33);
    wr(8, 32'd44);
    wr(5, 32'd1);
    wr(8, 32'd999);
    wait_done(2, lat);
    chk("t5_latency", lat, N + 1);
    chk("t5_pass", int'(o_pass), 1);
    wr(6, 32'd0);
    tick();
    chk("t5_hold_pass", int'(o_pass), 1);

    // Timeout of 50 RUN cycles; a start pulse mid-run is ignored
    i_timeout = 16'd50;
    start();
    k = 0;
    while (!o_timeout && k < 200) begin
      i_start = (k == 10);
      tick();
      k++;
    end
    i_start = 1'b0;
    chk("t6_tmo_cycles", k, 50);
    chk("t6_timeout", int'(o_timeout), 1);
    chk("t6_core_rst_n", int'(o_core_rst_n), 0);
    chk("t6_pass", int'(o_pass), 0);

    // Timeout disabled: still running after 10000 cycles
    i_timeout   = 16'd0;
    i_done_addr = 8'd0;
    start();
    repeat (10000) tick();
    chk("t7_busy", int'(o_busy), 1);
    chk("t7_timeout", int'(o_timeout), 0);
    wr(0, 32'd1);
    wait_done(1, lat);

    // Reset mid-CHECK, then a clean rerun without stale shadows
    start();
    wr(5, 32'd1);
    wr(6, 32'd22);
    wr(7, 32'd33);
    wr(8, 32'd44);
    wr(0, 32'd1);
    tick();
    chk("t8_in_check", int'(o_busy), 1);
    i_rst_n = 1'b0;
    #1;
    chk_all_reset("midchk");
    tick();
    i_rst_n = 1'b1;
    tick();
    start();
    wr(6, 32'd22);
    wr(7, 32'd33);
    wr(8, 32'd44);
    wr(0, 32'd1);
    wait_done(1, lat);
    chk("t8_err", int'(o_err_cnt), 1);
    chk("t8_first_fail", int'(o_first_fail), 0);
    chk("t8_pass", int'(o_pass), 0);

    tick();
    compare_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_result_monitor.md
MIPS_RESULT_MONITOR -- requirements
Module: mips_result_monitor

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_W, 32, data-memory word width
- ADDR_W, 8, data-memory word-address width
- NUM_CHECKS, 4, number of result slots (1..16)
- TMO_W, 16, timeout counter width
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- i_clk  in  1  single clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_start  in  1  one-cycle pulse that launches a run
- i_done_addr  in  ADDR_W  address of the completion flag word
- i_chk_addr  in  NUM_CHECKS*ADDR_W  slot k address at bits [k*ADDR_W +: ADDR_W]
- i_chk_exp  in  NUM_CHECKS*DATA_W  slot k expected value, same packing
- i_timeout  in  TMO_W  maximum RUN cycles; 0 disables the timeout
- i_mem_we  in  1  snooped data-memory write enable
- i_mem_addr  in  ADDR_W  snooped write address
- i_mem_wdata  in  DATA_W  snooped write data
- o_core_rst_n  out  1  active-low reset driven to the MIPS core
- o_busy  out  1  high in RUN or CHECK
- o_done  out  1  high in DONE or TMO
- o_pass  out  1  high in DONE when err_cnt==0
- o_timeout  out  1  high in TMO
- o_err_cnt  out  5  number of mismatching slots
- o_first_fail  out  4  lowest failing slot index; 0 if none

Function
REQ-003 The FSM SHALL have states IDLE, RUN, CHECK, DONE and TMO.
REQ-004 IDLE: o_core_rst_n=0; on i_start the FSM SHALL go to RUN next cycle, clear all shadow registers, valid bits, error count and cycle counter.
REQ-005 RUN: o_core_rst_n=1; every cycle with i_mem_we=1, each slot whose address equals i_mem_addr SHALL capture i_mem_wdata and set its valid bit; duplicate addresses update all matching slots.
REQ-006 RUN: a write with i_mem_addr==i_done_addr and i_mem_wdata==1 SHALL move the FSM to CHECK next cycle; done-address writes of any other value SHALL be ignored for completion.
REQ-007 If a write in the same cycle hits both the done address and a check address, the slot capture SHALL occur before checking starts.
REQ-008 RUN: the cycle counter SHALL increment each cycle; when i_timeout!=0 and the counter reaches i_timeout with no completion, the FSM SHALL go to TMO; completion and timeout in the same cycle SHALL resolve to CHECK.
REQ-009 CHECK: o_core_rst_n=0; one slot SHALL be compared per cycle, index 0 up to NUM_CHECKS-1; a slot mismatches if its valid bit is 0 or shadow!=expected (full DATA_W bitwise compare).
REQ-010 On each mismatch err_cnt SHALL increment; the first mismatch SHALL latch o_first_fail.
REQ-011 CHECK SHALL last exactly NUM_CHECKS cycles, then go to DONE; pass/fail SHALL be valid NUM_CHECKS+1 cycles after the completion write.
REQ-012 DONE/TMO: o_core_rst_n=0; outputs SHALL hold until i_start, which restarts as in REQ-004; i_start in RUN or CHECK SHALL be ignored.
REQ-013 Snooped writes outside RUN SHALL be ignored.

Reset
REQ-014 Asserting i_rst_n low at any time, including mid-RUN or mid-CHECK, SHALL immediately force IDLE, o_core_rst_n=0, o_busy=0, o_done=0, o_pass=0, o_timeout=0, o_err_cnt=0, o_first_fail=0, and clear shadows, valid bits and counters.

Structure
REQ-015 The state encoding and the default parameter values SHALL live in a shared package mips_tb_pkg.
REQ-016 A per-slot capture sub-module mips_result_slot (address match, shadow register, valid bit) SHALL be instantiated NUM_CHECKS times via generate.

Verification
REQ-017 Slot0 addr5 exp3500, done addr0; core writes mem[5]=3500 and then mem[0]=1 -> DONE, o_pass=1, o_err_cnt=0, latency NUM_CHECKS+1 cycles.
REQ-018 Slots at addr15..18 exp 100, 0x80000000, 200, 0x7FFFFFFF; core writes 0x7FFFFFFE to addr18 -> o_pass=0, o_err_cnt=1, o_first_fail=3.
REQ-019 Slot addr12 never written, done at addr11 -> o_err_cnt=1 (valid-bit failure).
REQ-020 i_timeout=50, no done write -> TMO after exactly 50 RUN cycles, o_timeout=1, o_core_rst_n=0; i_timeout=0 -> no timeout after 10000 cycles.
REQ-021 mem[0]=2 then mem[0]=1 -> only the second write completes; mem[5] and done written in the same cycle -> mem[5] value is captured.
REQ-022 i_rst_n pulsed low mid-CHECK -> all outputs at reset values the same cycle; a new i_start runs cleanly with no stale shadow values.
